// File: rtl/servo_pwm_bank_if.sv
// Write port and pin outputs of servo_pwm_bank, bundled as one interface.
//
// Signals:
//   wr_en        write strobe, one cycle per write (no backpressure)
//   wr_ch        channel index; indices >= NUM_CH are ignored by the bank
//   wr_pos       target position code
//   pwm          servo pulse outputs, one bit per channel
//   frame_start  one-cycle pulse after each frame wrap
//   all_settled  every channel's current position equals its target
//
// Modports: master = control side (drives writes), slave = the PWM bank.
interface servo_pwm_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned POS_W  = 8,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [POS_W-1:0]  wr_pos;
    logic [NUM_CH-1:0] pwm;
    logic              frame_start;
    logic              all_settled;

    modport master (
        output wr_en, wr_ch, wr_pos,
        input  pwm, frame_start, all_settled
    );

    modport slave (
        input  wr_en, wr_ch, wr_pos,
        output pwm, frame_start, all_settled
    );
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel RC-servo PWM generator sharing one microsecond timebase.
//
// Each channel holds a target position (written through the bus) and a current
// position. The current position is only updated at a frame wrap, so a pulse
// width never changes inside a frame. Pulse width in us is
//   MIN_US + ((cur * (MAX_US - MIN_US)) >> POS_W).
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   servo_pwm_bank_if.slave: wr_en/wr_ch/wr_pos in; pwm/frame_start/all_settled out
//
// Build option: define SERVO_SLEW_EN to limit each channel's position change to
// SLEW_STEP codes per frame. Without it the current position jumps straight to
// the target at each wrap and SLEW_STEP only takes part in the parameter check.
module servo_pwm_bank #(
    parameter int unsigned CLK_FREQUENCY = 12000000,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned POS_W         = 8,
    parameter int unsigned FRAME_US      = 20000,
    parameter int unsigned MIN_US        = 1000,
    parameter int unsigned MAX_US        = 2000,
    parameter int unsigned SLEW_STEP     = 1
) (
    input logic             clk,
    input logic             rst,
    servo_pwm_bank_if.slave bus
);

    localparam int unsigned DIV    = CLK_FREQUENCY / 1000000;
    localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned US_W   = $clog2(FRAME_US);
    localparam int unsigned SPAN   = MAX_US - MIN_US;
    localparam int unsigned PROD_W = POS_W + $clog2(SPAN + 1);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [POS_W-1:0] POS_MID = POS_W'(1 << (POS_W - 1));

    localparam bit CFG_OK = (DIV * 1000000 == CLK_FREQUENCY) && (DIV >= 2) &&
                            (NUM_CH >= 1) && (NUM_CH <= 16) && (POS_W >= 1) &&
                            (MIN_US < MAX_US) && (MAX_US < FRAME_US) && (SLEW_STEP >= 1);

    if (!CFG_OK) begin : g_cfg_check
        $error("servo_pwm_bank: inconsistent parameter set");
    end

    // Timebase
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [US_W-1:0]  us_q, us_d;
    logic             us_tick;
    logic             wrap;

    // Per-channel positions and derived widths
    logic [POS_W-1:0] tgt_q [NUM_CH];
    logic [POS_W-1:0] tgt_d [NUM_CH];
    logic [POS_W-1:0] cur_q [NUM_CH];
    logic [POS_W-1:0] cur_d [NUM_CH];
    logic [US_W-1:0]  width [NUM_CH];

    // Registered outputs
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              fs_q, fs_d;
    logic              settled_q, settled_d;

`ifdef SERVO_SLEW_EN
    // Move cur toward tgt by at most SLEW_STEP, landing exactly on tgt.
    function automatic logic [POS_W-1:0] step_toward(input logic [POS_W-1:0] cur,
                                                     input logic [POS_W-1:0] tgt);
        logic [POS_W-1:0] gap;
        step_toward = tgt;
        if (cur < tgt) begin
            gap = tgt - cur;
            if (32'(gap) > SLEW_STEP) step_toward = cur + POS_W'(SLEW_STEP);
        end else begin
            gap = cur - tgt;
            if (32'(gap) > SLEW_STEP) step_toward = cur - POS_W'(SLEW_STEP);
        end
    endfunction
`endif

    always_comb begin
        us_tick = (pre_q == PRE_W'(DIV - 1));
        wrap    = us_tick && (us_q == US_W'(FRAME_US - 1));

        pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
        us_d  = us_q;
        if (us_tick) begin
            us_d = wrap ? '0 : us_q + US_W'(1);
        end

        // Out-of-range channel indices match no slot and are dropped.
        for (int i = 0; i < NUM_CH; i++) begin
            tgt_d[i] = tgt_q[i];
            if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                tgt_d[i] = bus.wr_pos;
            end
        end

        // cur follows the pre-edge target, so a write in the wrap cycle waits a frame.
        for (int i = 0; i < NUM_CH; i++) begin
            cur_d[i] = cur_q[i];
            if (wrap) begin
`ifdef SERVO_SLEW_EN
                cur_d[i] = step_toward(cur_q[i], tgt_q[i]);
`else
                cur_d[i] = tgt_q[i];
`endif
            end
        end

        // The compare sees us_cnt == FRAME_US-1 at the wrap edge, which is never
        // inside a pulse, so using cur_q here equals using the freshly updated value.
        for (int i = 0; i < NUM_CH; i++) begin
            width[i] = US_W'(MIN_US) +
                       US_W'((PROD_W'(cur_q[i]) * PROD_W'(SPAN)) >> POS_W);
            pwm_d[i] = (us_q < width[i]);
        end

        fs_d = wrap;

        settled_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_q[i] != tgt_q[i]) settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= '0;
            us_q      <= '0;
            pwm_q     <= '0;
            fs_q      <= 1'b0;
            settled_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= POS_MID;
                cur_q[i] <= POS_MID;
            end
        end else begin
            pre_q     <= pre_d;
            us_q      <= us_d;
            pwm_q     <= pwm_d;
            fs_q      <= fs_d;
            settled_q <= settled_d;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign bus.pwm         = pwm_q;
    assign bus.frame_start = fs_q;
    assign bus.all_settled = settled_q;

endmodule
